key_sched_ctrl: RTL

//   Key-schedule controller for the USB encryptor cipher path. Stores a KEY_WORDS-word key loaded by the host side.
//   Per data block, streams KEY_WORDS x ROUNDS round-key words to the cipher core over a valid/ready handshake.

---
 rtl/key_sched_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// key_sched_ctrl
//   Key-schedule controller for the USB encryptor cipher path.
//   Holds a KEY_WORDS-word key written by the host side, then, for every data
//   block, streams KEY_WORDS x ROUNDS round-key words to the cipher core over a
//   valid/ready handshake. Each round-key word is the stored key word rotated
//   left by (round mod WORD_W).
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous active-high reset
//   key_clear   in   1       synchronous zeroize (beats everything but rst)
//   key_wr      in   1       key word write strobe
//   key_wdata   in   WORD_W  key word, written at the internal write pointer
//   key_wready  out  1       key writes accepted (EMPTY, LOAD, READY)
//   key_valid   out  1       complete key held (READY, RUN, DONE)
//   blk_start   in   1       start one block's key stream (READY only)
//   blk_busy    out  1       block in progress (RUN, DONE)
//   blk_done    out  1       one-cycle block completion pulse
//   rk_valid    out  1       round-key word valid (RUN only)
//   rk_ready    in   1       cipher core accepts the current word
//   rk_data     out  WORD_W  round-key word
//   rk_word     out  IDX_W   current key-word index
//   rk_round    out  RND_W   current round
// -----------------------------------------------------------------------------
module key_sched_ctrl #(
   parameter int WORD_W    = 32,
   parameter int KEY_WORDS = 4,
   parameter int ROUNDS    = 10,
   parameter int IDX_W     = $clog2(KEY_WORDS),
   parameter int RND_W     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_clear,
   input  logic              key_wr,
   input  logic [WORD_W-1:0] key_wdata,
   output logic              key_wready,
   output logic              key_valid,
   input  logic              blk_start,
   output logic              blk_busy,
   output logic              blk_done,
   output logic              rk_valid,
   input  logic              rk_ready,
   output logic [WORD_W-1:0] rk_data,
   output logic [IDX_W-1:0]  rk_word,
   output logic [RND_W-1:0]  rk_round
);

   typedef enum logic [2:0] {
      ST_EMPTY = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(KEY_WORDS - 1);
   localparam logic [RND_W-1:0] LAST_RND  = RND_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [RND_W-1:0] RND_ONE   = RND_W'(1);

   // Rotate left by amt (0 <= amt < WORD_W): the upper half of the doubled
   // word shifted left is exactly the rotated word.
   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] w,
                                              input int                amt);
      logic [2*WORD_W-1:0] dbl;
      dbl = {w, w} << amt;
      return dbl[2*WORD_W-1:WORD_W];
   endfunction

   state_t              state_q,  state_d;
   logic [WORD_W-1:0]   key_q [KEY_WORDS];
   logic [WORD_W-1:0]   key_d [KEY_WORDS];
   logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]    rk_word_q, rk_word_d;
   logic [RND_W-1:0]    rk_round_q, rk_round_d;

   logic                run_s;
   logic                hs_s;
   int                  rot_amt_s;

   assign run_s = (state_q == ST_RUN);
   assign hs_s  = run_s & rk_ready;

   // Next-state, key-store and counter sequencing.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rk_word_d  = rk_word_q;
      rk_round_d = rk_round_q;
      for (int i = 0; i < KEY_WORDS; i++) begin
         key_d[i] = key_q[i];
      end

      if (key_clear) begin
         // Zeroize: identical to the reset image; an aborted block never
         // reaches DONE, so no blk_done is produced.
         state_d    = ST_EMPTY;
         wr_ptr_d   = '0;
         rk_word_d  = '0;
         rk_round_d = '0;
         for (int i = 0; i < KEY_WORDS; i++) begin
            key_d[i] = '0;
         end
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (key_wr) begin
                  key_d[0] = key_wdata;
                  wr_ptr_d = IDX_ONE;
                  state_d  = ST_LOAD;
               end else begin
                  state_d  = ST_EMPTY;
               end
            end

            ST_LOAD: begin
               if (key_wr) begin
                  key_d[wr_ptr_q] = key_wdata;
                  if (wr_ptr_q == LAST_WORD) begin
                     wr_ptr_d = '0;
                     state_d  = ST_READY;
                  end else begin
                     wr_ptr_d = wr_ptr_q + IDX_ONE;
                  end
               end else begin
                  state_d = ST_LOAD;
               end
            end

            ST_READY: begin
               // A key write wins over blk_start; the start is dropped,
               // not queued, and the key becomes invalid until reloaded.
               if (key_wr) begin
                  key_d[0] = key_wdata;
                  wr_ptr_d = IDX_ONE;
                  state_d  = ST_LOAD;
               end else if (blk_start) begin
                  rk_word_d  = '0;
                  rk_round_d = '0;
                  state_d    = ST_RUN;
               end else begin
                  state_d = ST_READY;
               end
            end

            ST_RUN: begin
               // Counters only move on a handshake, so a stalled word and
               // its index/round stay stable.
               if (hs_s) begin
                  if (rk_word_q == LAST_WORD) begin
                     rk_word_d = '0;
                     if (rk_round_q == LAST_RND) begin
                        rk_round_d = '0;
                        state_d    = ST_DONE;
                     end else begin
                        rk_round_d = rk_round_q + RND_ONE;
                     end
                  end else begin
                     rk_word_d = rk_word_q + IDX_ONE;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end

            ST_DONE: begin
               rk_word_d  = '0;
               rk_round_d = '0;
               state_d    = ST_READY;
            end

            default: begin
               state_d    = ST_EMPTY;
               wr_ptr_d   = '0;
               rk_word_d  = '0;
               rk_round_d = '0;
            end
         endcase
      end
   end

   // State, key store and counters; asynchronous reset to the empty image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         wr_ptr_q   <= '0;
         rk_word_q  <= '0;
         rk_round_q <= '0;
         for (int i = 0; i < KEY_WORDS; i++) begin
            key_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rk_word_q  <= rk_word_d;
         rk_round_q <= rk_round_d;
         for (int i = 0; i < KEY_WORDS; i++) begin
            key_q[i] <= key_d[i];
         end
      end
   end

   // Status outputs decoded directly from the state register so that an
   // asynchronous reset is visible on them in the same cycle.
   always_comb begin
      key_wready = 1'b0;
      key_valid  = 1'b0;
      blk_busy   = 1'b0;
      blk_done   = 1'b0;
      rk_valid   = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            key_wready = 1'b1;
         end
         ST_LOAD: begin
            key_wready = 1'b1;
         end
         ST_READY: begin
            key_wready = 1'b1;
            key_valid  = 1'b1;
         end
         ST_RUN: begin
            key_valid  = 1'b1;
            blk_busy   = 1'b1;
            rk_valid   = 1'b1;
         end
         ST_DONE: begin
            key_valid  = 1'b1;
            blk_busy   = 1'b1;
            blk_done   = 1'b1;
         end
         default: begin
            key_wready = 1'b0;
         end
      endcase
   end

   // Round-key word: selected key word rotated by the round number.
   always_comb begin
      rot_amt_s = int'(rk_round_q) % WORD_W;
      rk_data   = rotl(key_q[rk_word_q], rot_amt_s);
      rk_word   = rk_word_q;
      rk_round  = rk_round_q;
   end

endmodule
